// File: rtl/flash_read_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// flash_read_sequencer: one 32-bit word read from SPI flash (build option QUAD_READ_EN = 0x6B quad read)
// Revision: 1.0
// ---------------------------------------------------------------------------
module flash_read_sequencer (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        req,
  input  logic [23:0] addr,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        fcen,
  output logic        fsclk,
  output logic [3:0]  fdo,
  output logic [3:0]  fdoe,
  input  logic [3:0]  fdi
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_DUMMY = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_CSHI  = 3'd5;

`ifdef QUAD_READ_EN
  localparam logic [7:0] CMD_OPCODE = 8'h6B;
  localparam logic [5:0] DATA_LAST  = 6'd7;
  localparam logic [3:0] DATA_OE    = 4'b0000;
  localparam logic [3:0] DATA_DO    = 4'b0000;
`else
  localparam logic [7:0] CMD_OPCODE = 8'h03;
  localparam logic [5:0] DATA_LAST  = 6'd31;
  localparam logic [3:0] DATA_OE    = 4'b1101;
  localparam logic [3:0] DATA_DO    = 4'b1100;
`endif

  logic [2:0]  state_q, state_d;
  logic        half_q, half_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] tx_q, tx_d;
  logic [31:0] rx_q, rx_d;
  logic [31:0] rdata_q, rdata_d;
  logic        done_q, done_d;
  logic [31:0] rx_shift;
  logic        in_xfer;

`ifdef QUAD_READ_EN
  assign rx_shift = {rx_q[27:0], fdi};
`else
  logic unused_fdi;
  assign unused_fdi = ^{fdi[3:2], fdi[0]};
  assign rx_shift   = {rx_q[30:0], fdi[1]};
`endif

  // Each SPI bit is two HCLK cycles; half_q=1 is the fsclk-high cycle whose end samples fdi.
  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        half_d = 1'b0;
        if (req) begin
          state_d = S_CMD;
          cnt_d   = 6'd7;
          tx_d    = {CMD_OPCODE, addr};
        end
      end
      S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
        half_d = ~half_q;
        if (half_q) begin
          tx_d = {tx_q[30:0], 1'b0};
          if (state_q == S_DATA) rx_d = rx_shift;
          if (cnt_q == 6'd0) begin
            case (state_q)
              S_CMD: begin
                state_d = S_ADDR;
                cnt_d   = 6'd23;
              end
              S_ADDR: begin
`ifdef QUAD_READ_EN
                state_d = S_DUMMY;
                cnt_d   = 6'd7;
`else
                state_d = S_DATA;
                cnt_d   = DATA_LAST;
`endif
              end
              S_DUMMY: begin
                state_d = S_DATA;
                cnt_d   = DATA_LAST;
              end
              default: begin
                // Bytes arrive lowest address first; present them little-endian.
                state_d = S_CSHI;
                rdata_d = {rx_shift[7:0], rx_shift[15:8], rx_shift[23:16], rx_shift[31:24]};
                done_d  = 1'b1;
              end
            endcase
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end
      end
      S_CSHI: begin
        half_d = ~half_q;
        if (half_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      half_q  <= 1'b0;
      cnt_q   <= 6'd0;
      tx_q    <= 32'h0;
      rx_q    <= 32'h0;
      rdata_q <= 32'h0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    in_xfer = (state_q == S_CMD) || (state_q == S_ADDR) ||
              (state_q == S_DUMMY) || (state_q == S_DATA);
    busy    = (state_q != S_IDLE);
    done    = done_q;
    rdata   = rdata_q;
    fcen    = ~in_xfer;
    fsclk   = in_xfer & half_q;
    fdo     = 4'b0000;
    fdoe    = 4'b0000;
    case (state_q)
      S_CMD, S_ADDR: begin
        fdo  = {3'b110, tx_q[31]};
        fdoe = 4'b1101;
      end
      S_DATA: begin
        fdo  = DATA_DO;
        fdoe = DATA_OE;
      end
      default: begin
        fdo  = 4'b0000;
        fdoe = 4'b0000;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_flash_read_sequencer.sv
`default_nettype none
// Directed bench for flash_read_sequencer with a behavioural SPI flash model.
module tb_flash_read_sequencer;

`ifdef QUAD_READ_EN
  localparam int N      = 48;
  localparam int DUM    = 8;
  localparam int DBITS  = 8;
  localparam logic [7:0] CMD_EXP = 8'h6B;
`else
  localparam int N      = 64;
  localparam int DUM    = 0;
  localparam int DBITS  = 32;
  localparam logic [7:0] CMD_EXP = 8'h03;
`endif

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        req;
  logic [23:0] addr;
  logic        busy, done, fcen, fsclk;
  logic [31:0] rdata;
  logic [3:0]  fdo, fdoe, fdi;

  flash_read_sequencer dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .req(req), .addr(addr),
    .busy(busy), .done(done), .rdata(rdata), .fcen(fcen), .fsclk(fsclk),
    .fdo(fdo), .fdoe(fdoe), .fdi(fdi)
  );

  always #5 HCLK = ~HCLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [7:0]  mem [0:511];
  int          cyc = 0, nclk = 0, d = 0, idx = 0;
  int          done_cnt = 0, fall_cnt = 0, cshi_cnt = 0, bad_fdo = 0, bad_sclk = 0;
  int          fall_t [0:7];
  logic        prev_fcen = 1'b1;
  logic [3:0]  prev_fdo = 4'h0;
  logic [7:0]  cmd_obs = 8'h0;
  logic [23:0] adr_obs = 24'h0;
  logic [7:0]  fb;

  // Flash model and protocol monitor, sampled 1 time unit after each rising edge.
  always @(posedge HCLK) begin
    #1;
    cyc++;
    if (done) done_cnt++;
    if (prev_fcen && !fcen) begin
      if (fall_cnt < 8) fall_t[fall_cnt] = cyc;
      fall_cnt++;
    end
    if (fcen && busy) cshi_cnt++;
    if (fsclk && fcen) bad_sclk++;
    if (fsclk && (fdo !== prev_fdo)) bad_fdo++;
    prev_fcen = fcen;
    prev_fdo  = fdo;
    if (fcen) begin
      nclk = 0;
    end else if (fsclk) begin
      if (nclk < 8) cmd_obs = {cmd_obs[6:0], fdo[0]};
      else if (nclk < 32) adr_obs = {adr_obs[22:0], fdo[0]};
      nclk++;
    end else begin
      d = nclk - 32 - DUM;
      if (d >= 0 && d < DBITS) begin
`ifdef QUAD_READ_EN
        idx = (int'(adr_obs) + d / 2) % 512;
        fb  = mem[idx];
        fdi = (d % 2 == 0) ? fb[7:4] : fb[3:0];
`else
        idx = (int'(adr_obs) + d / 8) % 512;
        fb  = mem[idx];
        fdi = {2'b00, fb[7 - (d % 8)], 1'b0};
`endif
      end
    end
  end

  task automatic do_read(input logic [23:0] a, output int lat);
    int w;
    w = 0;
    @(negedge HCLK);
    while (busy && w < 400) begin
      @(negedge HCLK);
      w++;
    end
    req  = 1'b1;
    addr = a;
    @(posedge HCLK);
    #1;
    req  = 1'b0;
    addr = 24'hFFFFFF;
    lat  = 1;
    while (!done && lat < 400) begin
      @(posedge HCLK);
      #1;
      lat++;
    end
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    @(negedge HCLK);
    while (busy && w < 400) begin
      @(negedge HCLK);
      w++;
    end
    check("idle_timeout", busy, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, w;
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h00; mem[3] = 8'h00;
    mem[9'h0FE] = 8'hAA; mem[9'h0FF] = 8'hBB; mem[9'h100] = 8'hCC; mem[9'h101] = 8'hDD;
    HRESETn = 1'b0; req = 1'b0; addr = 24'h0; fdi = 4'h0;
    repeat (3) @(posedge HCLK);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_fcen", fcen, 1'b1);
    check("rst_fsclk", fsclk, 1'b0);
    check("rst_fdo", fdo, 4'h0);
    check("rst_fdoe", fdoe, 4'h0);
    check("rst_rdata", rdata, 32'h0);
    @(negedge HCLK);
    HRESETn = 1'b1;

    // Word at 0, first request right after reset release.
    do_read(24'h000000, lat);
    check("lat_addr0", lat, 2 * N + 1);
    check("rdata_addr0", rdata, 32'h00000513);
    check("cmd_addr0", cmd_obs, CMD_EXP);
    check("adr_addr0", adr_obs, 24'h000000);
    repeat (6) @(posedge HCLK);
    #1;
    check("rdata_hold", rdata, 32'h00000513);
    check("idle_fcen", fcen, 1'b1);
    check("idle_fdoe", fdoe, 4'h0);

    // Unaligned word crossing a 256-byte boundary; addr is scrambled after acceptance.
    do_read(24'h0000FE, lat);
    check("lat_addrFE", lat, 2 * N + 1);
    check("rdata_addrFE", rdata, 32'hDDCCBBAA);
    check("adr_addrFE", adr_obs, 24'h0000FE);
    check("cmd_addrFE", cmd_obs, CMD_EXP);

    // A request while busy is dropped.
    wait_idle();
    done_cnt = 0; fall_cnt = 0;
    req = 1'b1; addr = 24'h000000;
    @(posedge HCLK);
    #1;
    req = 1'b0;
    repeat (9) @(posedge HCLK);
    #1;
    req = 1'b1; addr = 24'h0000FE;
    @(posedge HCLK);
    #1;
    req = 1'b0;
    wait_idle();
    repeat (10) @(negedge HCLK);
    check("ign_done_cnt", done_cnt, 1);
    check("ign_fcen_windows", fall_cnt, 1);
    check("ign_rdata", rdata, 32'h00000513);

    // Reset in the middle of the address phase.
    wait_idle();
    done_cnt = 0;
    req = 1'b1; addr = 24'h0000FE;
    @(posedge HCLK);
    #1;
    req = 1'b0;
    repeat (20) @(posedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b0;
    #1;
    check("mid_rst_fcen", fcen, 1'b1);
    check("mid_rst_fdoe", fdoe, 4'h0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_rdata", rdata, 32'h0);
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (2 * N + 10) @(negedge HCLK);
    check("mid_rst_no_done", done_cnt, 0);
    do_read(24'h0000FE, lat);
    check("post_rst_lat", lat, 2 * N + 1);
    check("post_rst_rdata", rdata, 32'hDDCCBBAA);

    // Request held high: back-to-back transfers.
    wait_idle();
    done_cnt = 0; fall_cnt = 0; cshi_cnt = 0;
    req = 1'b1; addr = 24'h000000;
    w = 0;
    while (fall_cnt < 3 && w < 3 * (2 * N + 3) + 20) begin
      @(negedge HCLK);
      w++;
    end
    req = 1'b0;
    check("b2b_windows", fall_cnt, 3);
    check("b2b_gap01", fall_t[1] - fall_t[0], 2 * N + 3);
    check("b2b_gap12", fall_t[2] - fall_t[1], 2 * N + 3);
    check("b2b_done_so_far", done_cnt, 2);
    check("b2b_cshi_cycles", cshi_cnt, 4);
    wait_idle();
    check("b2b_done_total", done_cnt, 3);
    check("b2b_rdata", rdata, 32'h00000513);

    check("fdo_stable_sclk_hi", bad_fdo, 0);
    check("sclk_quiet_cs_hi", bad_sclk, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/flash_read_sequencer.md
FLASH_READ_SEQUENCER -- requirements
Module: flash_read_sequencer

Interface
REQ-001 HCLK  input  1  system clock; all state changes on rising edge.
REQ-002 HRESETn  input  1  asynchronous active-low reset.
REQ-003 req  input  1  word read request; sampled only while busy=0.
REQ-004 addr  input  24  byte address of the word; captured on acceptance.
REQ-005 busy  output  1  high from the cycle after acceptance until the sequencer returns to IDLE.
REQ-006 done  output  1  one-HCLK pulse; rdata is valid from this cycle until the next acceptance.
REQ-007 rdata  output  32  read word, little-endian: rdata[7:0] = byte at addr, rdata[31:24] = byte at addr+3.
REQ-008 fcen  output  1  flash chip enable, active-low.
REQ-009 fsclk  output  1  flash serial clock, HCLK/2.
REQ-010 fdo  output  4  flash IO output values.
REQ-011 fdoe  output  4  per-pin output enable for fdo (1 = drive).
REQ-012 fdi  input  4  flash IO input values.

Function
REQ-013 States and transitions:
- IDLE -> CMD -> ADDR -> [DUMMY] -> DATA -> CSHI -> IDLE.
- DUMMY exists only with QUAD_READ_EN.
REQ-014 Acceptance: req=1 and busy=0 at a rising HCLK edge. From the next cycle, fcen=0 and busy=1.
REQ-015 Each SPI bit occupies two HCLK cycles:
- First cycle: fsclk=0, and outputs change only in this cycle.
- Second cycle: fsclk=1, and fdi is sampled at the end of this cycle.
REQ-016 CMD phase: 8 bits, MSB first, on fdo[0]; fdoe=4'b1101; fdo[3:2]=2'b11.
REQ-017 ADDR phase: 24 bits of the captured address, MSB first, on fdo[0], with the same fdoe as CMD.
REQ-018 DATA phase: 4 bytes in ascending address order, each byte MSB first.
REQ-019 CSHI state: 2 HCLK cycles with fcen=1 and fsclk=0.
- done=1 and rdata updated in the first CSHI cycle.
- busy stays 1 through both CSHI cycles.
- The state then returns to IDLE.
REQ-020 req while busy=1 is ignored, with no queuing; addr changes after acceptance have no effect.
REQ-021 IDLE outputs: fcen=1, fsclk=0, fdo=4'b0000, fdoe=4'b0000, done=0.
REQ-022 done rises exactly 2N+1 HCLK cycles after the acceptance edge, where N is the total fsclk count of the transfer. The earliest next acceptance is 2N+3 cycles after the previous acceptance.
REQ-023 rdata holds its last value across IDLE and across ignored requests.

Reset
REQ-024 HRESETn=0 forces the following immediately, regardless of state, including mid-transfer:
- state=IDLE, fcen=1, fsclk=0;
- fdo=0, fdoe=0;
- busy=0, done=0, rdata=32'h0.
REQ-025 A transfer interrupted by reset is abandoned; no done pulse is produced for it.
REQ-026 After reset release, the first req is acceptable at the first rising HCLK edge with HRESETn=1.

Configuration
REQ-027 Macro QUAD_READ_EN defined (quad read):
- Command 8'h6B.
- DUMMY phase of 8 fsclk with fdoe=4'b0000.
- DATA phase of 8 fsclk with fdoe=4'b0000, sampling fdi[3:0], high nibble first.
- N=48, so done is 97 HCLK cycles after acceptance.
REQ-028 Macro QUAD_READ_EN undefined (single read):
- Command 8'h03, with no DUMMY phase.
- DATA phase of 32 fsclk, sampling fdi[1], with fdoe=4'b1101 and fdo[3:2]=2'b11.
- N=64, so done is 129 HCLK cycles after acceptance.

Verification
REQ-029 Flash model bytes 0x000000..3 = 13 05 00 00; req with addr=24'h000000 -> rdata=32'h00000513, done after 129 cycles (97 with QUAD_READ_EN).
REQ-030 addr=24'h0000FE, bytes at FE..101 = AA BB CC DD -> rdata=32'hDDCCBBAA; the address bits shifted on fdo[0] equal 24'h0000FE.
REQ-031 Second req pulsed 10 cycles after acceptance -> no second transfer; exactly one done pulse; fcen shows exactly one low window.
REQ-032 HRESETn=0 during the ADDR phase -> fcen=1, fdoe=0, busy=0 in the same cycle; no done; a new req afterwards completes correctly.
REQ-033 req held high continuously -> back-to-back transfers with fcen high for exactly 2 cycles between them (CSHI), each ending in one done pulse.
REQ-034 Per-bit check:
- fdo changes only while fsclk=0.
- fsclk never toggles while fcen=1.
- The CMD bits observed are 8'h03, or 8'h6B with QUAD_READ_EN.
